// File: rtl/if_fetch_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_buf
//
// Instruction fetch front end: holds the fetch PC, issues sequential word
// requests to instruction memory under a credit limit, collects in-order
// responses into a small FIFO and presents the head entry to decode. A
// redirect flushes the FIFO and discards every response still owed for
// requests issued before it. A misaligned PC produces a single address-error
// entry instead of a memory request and then halts fetch until the next
// redirect.
//
// Ports
//   cpu_clk_50M        in   clock, all state updates on the rising edge
//   cpu_rst_n          in   synchronous active-low reset
//   stall_i            in   blocks new memory requests
//   redirect_i         in   flush and refetch from redirect_pc_i
//   redirect_pc_i      in   redirect virtual address
//   imem_req_o         out  fetch request
//   imem_addr_o        out  physical fetch address {3'b0, pc[28:0]}
//   imem_gnt_i         in   request accepted when high with imem_req_o
//   imem_rvalid_i      in   in-order response strobe
//   imem_rdata_i       in   instruction word of the response
//   id_valid_o         out  buffer head is valid
//   id_ready_i         in   decode ready, pops the head when id_valid_o is high
//   id_inst_o          out  head instruction word
//   id_pc_o            out  head virtual PC
//   id_exc_code_o      out  head exception code
//   id_exc_badvaddr_o  out  head faulting virtual address
// ---------------------------------------------------------------------------

`ifndef ExcCode
`define ExcCode 4:0
`endif

module if_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic            cpu_clk_50M,
    input  logic            cpu_rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic            imem_req_o,
    output logic [31:0]     imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [31:0]     id_inst_o,
    output logic [31:0]     id_pc_o,
    output logic [`ExcCode] id_exc_code_o,
    output logic [31:0]     id_exc_badvaddr_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DROP_W = 16;

    localparam logic [4:0] EC_NONE = 5'h00;
    localparam logic [4:0] EC_ADEL = 5'h04;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  exc_code;
        logic [31:0] badvaddr;
    } entry_t;

    entry_t              fifo_q [DEPTH];
    entry_t              fifo_d [DEPTH];
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                halt_q, halt_d;

    logic [CNT_W:0]      credit_used;
    logic                credit_ok;
    logic                fetch_grant;
    logic                resp_accept;
    logic                resp_drop;
    logic                misaligned;
    logic                push;
    logic                pop;
    entry_t              push_entry;
    entry_t              head;
    logic [DROP_W-1:0]   stale;

    // Credit covers both live requests and held entries, so every response
    // that is not being dropped is guaranteed a free FIFO slot.
    always_comb begin
        credit_used = {1'b0, outst_q} + {1'b0, count_q};
        credit_ok   = credit_used < (CNT_W + 1)'(DEPTH);
    end

    assign imem_req_o  = cpu_rst_n && !redirect_i && !stall_i && !halt_q &&
                         (pc_q[1:0] == 2'b00) && credit_ok;
    assign imem_addr_o = {3'b000, pc_q[28:0]};

    // Event decode for this cycle. A redirect swallows any response arriving
    // alongside it, so every event below is qualified by !redirect_i.
    always_comb begin
        fetch_grant = imem_req_o && imem_gnt_i;
        resp_accept = imem_rvalid_i && !redirect_i && (drop_q == '0) && (outst_q != '0);
        resp_drop   = imem_rvalid_i && !redirect_i && (drop_q != '0);
        misaligned  = !redirect_i && (pc_q[1:0] != 2'b00) && !halt_q &&
                      (outst_q == '0) && (count_q < CNT_W'(DEPTH)) && !stall_i;
        pop         = (count_q != '0) && id_ready_i && !redirect_i;
        push        = resp_accept || misaligned;

        // Misaligned handling needs no live requests, so it never competes
        // with an accepted response for the single write port.
        push_entry = '0;
        if (misaligned) begin
            push_entry.inst     = 32'h0;
            push_entry.pc       = pc_q;
            push_entry.exc_code = EC_ADEL;
            push_entry.badvaddr = pc_q;
        end else begin
            push_entry.inst     = imem_rdata_i;
            push_entry.pc       = resp_pc_q;
            push_entry.exc_code = EC_NONE;
            push_entry.badvaddr = 32'h0;
        end
    end

    // Next-state logic. resp_pc tracks the PC of the next response that will
    // be kept; fetch is strictly sequential after a redirect, so it only needs
    // reloading on redirect and bumping on each accepted response.
    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        outst_d   = outst_q;
        drop_d    = drop_q;
        halt_d    = halt_q;
        stale     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end

        if (redirect_i) begin
            // Everything owed by memory becomes stale, minus a response that
            // completes in this very cycle.
            stale = drop_q + DROP_W'(outst_q);
            if (imem_rvalid_i && (stale != '0)) begin
                stale = stale - DROP_W'(1);
            end
            pc_d      = redirect_pc_i;
            resp_pc_d = redirect_pc_i;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            outst_d   = '0;
            drop_d    = stale;
            halt_d    = 1'b0;
        end else begin
            if (fetch_grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_accept) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (misaligned) begin
                halt_d = 1'b1;
            end
            if (push) begin
                fifo_d[wr_ptr_q] = push_entry;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            outst_d = outst_q + CNT_W'(fetch_grant) - CNT_W'(resp_accept);
            drop_d  = drop_q - DROP_W'(resp_drop);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            drop_q    <= '0;
            halt_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            halt_q    <= halt_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // Head fields read as zero while the buffer is empty, which also gives
    // the all-zero decode view right after reset.
    always_comb begin
        head              = fifo_q[rd_ptr_q];
        id_valid_o        = (count_q != '0);
        id_inst_o         = 32'h0;
        id_pc_o           = 32'h0;
        id_exc_code_o     = EC_NONE;
        id_exc_badvaddr_o = 32'h0;
        if (id_valid_o) begin
            id_inst_o         = head.inst;
            id_pc_o           = head.pc;
            id_exc_code_o     = head.exc_code;
            id_exc_badvaddr_o = head.badvaddr;
        end
    end

endmodule
